seq_mult_bcd_display: RTL and testbench
=======================================

SEQ_MULT_BCD_DISPLAY -- requirements
Module: seq_mult_bcd_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..16.
REQ-002 SHALL derive localparam DIGITS = (2*WIDTH*77)/256 + 1, the decimal digit count for the product; WIDTH=8 gives DIGITS=5.
REQ-003 SHALL have port clk, input, 1, rising-edge system clock; the block uses one clock only.
REQ-004 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin a multiply.
REQ-006 SHALL have ports a and b, input, WIDTH each, unsigned operands sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port product, output, 2*WIDTH, unsigned binary result.
REQ-010 SHALL have port seg, output, 7*DIGITS, packed {MS digit ... LS digit}.
- Each digit field is {g,f,e,d,c,b,a}.
- Segments are active-low.

Function
REQ-011 SHALL implement an FSM with states IDLE, MULT, CONV and DONE.
REQ-012 SHALL accept start only in IDLE: latch a and b, clear the accumulator, go to MULT.
REQ-013 SHALL perform shift-add in MULT, one multiplier bit per cycle, LSB first, for exactly WIDTH cycles; no overflow is possible in 2*WIDTH bits.
REQ-014 SHALL convert the product to BCD in CONV by double-dabble over exactly 2*WIDTH cycles.
- Each cycle: add 3 to every BCD nibble >= 5, then shift left by one.
REQ-015 SHALL, in DONE, register product and seg, assert done for exactly one cycle, then return to IDLE.
REQ-016 SHALL give a latency of 3*WIDTH+1 cycles from the start-accept edge to the edge that raises done; for WIDTH=8 this is 25.
REQ-017 SHALL drive busy high in MULT, CONV and DONE, and low in IDLE.
REQ-018 SHALL ignore start while busy; the operands are not re-latched.
REQ-019 SHALL accept a start asserted in the cycle after done, which starts a new operation (back-to-back operation).
REQ-020 SHALL hold product and seg at their last completed values until the next DONE; they never show intermediate values.
REQ-021 SHALL encode each BCD digit 0-9 to standard 7-segment; codes 10-15 cannot occur, and the encoder default is all segments off.
REQ-022 SHALL handle a zero operand with the full WIDTH-cycle latency; there is no early termination.

Reset
REQ-023 SHALL, with rst high at a clock edge, force state IDLE, busy=0, done=0, product=0, seg all ones (blank), and clear internal registers.
REQ-024 SHALL let reset mid-operation abort the operation; no done is produced, and start is honoured from the first edge after rst falls.
REQ-025 SHALL give rst priority over start on the same edge.

Configuration
REQ-026 SHALL support macro LEADING_ZERO_BLANK_EN.
- Defined: every digit more significant than the most significant non-zero digit is blank (7'b1111111); the LS digit is always shown, so 0 displays as "0".
- Undefined: all DIGITS digits are shown, including leading zeros.

Structure
REQ-027 SHALL place in package seg_mult_pkg:
- typedef enum state_t {IDLE, MULT, CONV, DONE};
- function/constant table for BCD-to-7-seg codes (active-low);
- constant SEG_BLANK = 7'b1111111.
REQ-028 SHALL use one sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit active-low segment out, combinational, instantiated DIGITS times with generate.

Verification (WIDTH=8)
REQ-029 SHALL cover: a=3, b=5, start pulse -> done 25 cycles later; product=15; LS digit 0010010 ("5"), next 1111001 ("1"); upper digits 1000000 ("0"), or 1111111 with LEADING_ZERO_BLANK_EN.
REQ-030 SHALL cover: a=255, b=255 -> product=65025; digits 6,5,0,2,5 from MS to LS.
REQ-031 SHALL cover: a=0, b=200 -> product=0 after 25 cycles; LS digit 1000000; upper digits 1111111 with LEADING_ZERO_BLANK_EN.
REQ-032 SHALL cover: start held high during a 100*200 operation -> exactly one done; product=20000; no second operation until start is re-asserted in IDLE.
REQ-033 SHALL cover: rst pulsed 10 cycles into a 123*45 operation -> no done; seg all ones; product=0; a following 123*45 start gives product=5535 at 25-cycle latency.
REQ-034 SHALL cover: back-to-back 9*9 then 255*1, start in the cycle after the first done -> outputs 81 then 255; done pulses exactly 26 cycles apart.

Source files
------------

// File: rtl/seg_mult_pkg.sv
// Shared types and the active-low BCD to 7-segment code table for seq_mult_bcd_display.
package seg_mult_pkg;

  typedef enum logic [1:0] {IDLE, MULT, CONV, DONE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Segment order {g,f,e,d,c,b,a}, active-low; codes 10-15 cannot occur and show blank.
  function automatic logic [6:0] bcd_seg_code(input logic [3:0] bcd);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational single-digit BCD to active-low 7-segment decoder.
module bcd_to_seg7
  import seg_mult_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd_seg_code(bcd_i);

endmodule

// File: rtl/seq_mult_bcd_display.sv
// Sequential shift-add multiplier with double-dabble BCD conversion and 7-segment output.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (LS digit always shown).
module seq_mult_bcd_display
  import seg_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned DIGITS = (2 * WIDTH * 77) / 256 + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [5:0] MultLast = 6'(WIDTH - 1);
  localparam logic [5:0] ConvLast = 6'(2 * WIDTH - 1);

  state_t              state_q, state_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [PW-1:0]       sh_q, sh_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [5:0]          cnt_q, cnt_d;
  logic [PW-1:0]       product_q, product_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, seg_raw, seg_disp;
  logic                done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_to_seg7 u_bcd_to_seg7 (
      .bcd_i (bcd_q[4*g +: 4]),
      .seg_o (seg_raw[7*g +: 7])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic lead;
    seg_disp = seg_raw;
    lead     = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead) seg_disp[7*i +: 7] = SEG_BLANK;
    end
  end
`else
  assign seg_disp = seg_raw;
`endif

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    seg_d     = seg_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(a);
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end
      end
      MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == MultLast) begin
          sh_d    = acc_d;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == ConvLast) state_d = DONE;
      end
      DONE: begin
        product_d = acc_q;
        seg_d     = seg_disp;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      seg_q     <= {DIGITS{SEG_BLANK}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_seq_mult_bcd_display.sv
// Self-checking bench for seq_mult_bcd_display (WIDTH=8) against a decimal reference model.
module tb_seq_mult_bcd_display;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;
  logic [34:0] seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult_bcd_display #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .seg     (seg)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] digit_code(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected display from the decimal representation of the product.
  function automatic logic [34:0] exp_seg(input int unsigned p);
    int unsigned q;
    logic [34:0] s;
`ifdef LEADING_ZERO_BLANK_EN
    int n;
    n = 1;
    q = p / 10;
    while (q != 0) begin
      n++;
      q = q / 10;
    end
`endif
    s = '0;
    q = p;
    for (int i = 0; i < DIGITS; i++) begin
      s[7*i +: 7] = digit_code(q % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i >= n) s[7*i +: 7] = 7'b1111111;
`endif
      q = q / 10;
    end
    return s;
  endfunction

  // Pulses start, then waits (bounded) for done; lat = -1 if it never comes.
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, output int lat,
                        output bit busy_ok, output logic [15:0] mid_prod);
    a = ai;
    b = bi;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    mid_prod = '0;
    for (int i = 1; i <= 100; i++) begin
      if (!busy) busy_ok = 1'b0;
      if (i == 12) mid_prod = product;
      tick;
      if (done) begin
        lat = i;
        if (busy) busy_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    a = 8'd7;
    b = 8'd9;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (product !== 16'd0) begin
      errors++; $display("FAIL reset_product: got %0d want 0", product);
    end
    checks++;
    if (seg !== {35{1'b1}}) begin
      errors++; $display("FAIL reset_seg: got %b want all ones", seg);
    end
    rst = 1'b0;
    start = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_priority_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_directed;
    logic [7:0] da [3];
    logic [7:0] db [3];
    int lat;
    bit bok;
    logic [15:0] mp;
    logic [15:0] want;
    da = '{8'd3, 8'd255, 8'd0};
    db = '{8'd5, 8'd255, 8'd200};
    for (int k = 0; k < 3; k++) begin
      run_op(da[k], db[k], lat, bok, mp);
      want = 16'(da[k] * db[k]);
      checks++;
      if (lat !== 25) begin errors++; $display("FAIL directed_latency: got %0d want 25", lat); end
      checks++;
      if (!bok) begin errors++; $display("FAIL directed_busy: got 0 want 1"); end
      checks++;
      if (product !== want) begin
        errors++; $display("FAIL directed_product: got %0d want %0d", product, want);
      end
      checks++;
      if (seg !== exp_seg(want)) begin
        errors++; $display("FAIL directed_seg: got %b want %b", seg, exp_seg(want));
      end
      if (k == 0) begin
        checks++;
        if (seg[13:0] !== 14'b1111001_0010010) begin
          errors++; $display("FAIL digits_15: got %b want 11110010010010", seg[13:0]);
        end
      end
    end
    repeat (3) tick;
    checks++;
    if (product !== 16'd0) begin errors++; $display("FAIL hold_product: got %0d want 0", product); end
  endtask

  task automatic test_random;
    int lat;
    bit bok;
    logic [15:0] mp;
    logic [7:0] ai, bi;
    logic [15:0] prev, want;
    prev = 16'd0;
    for (int k = 0; k < 20; k++) begin
      ai = 8'($urandom_range(0, 255));
      bi = 8'($urandom_range(0, 255));
      if (k == 3) ai = 8'd1;
      if (k == 5) bi = 8'd0;
      run_op(ai, bi, lat, bok, mp);
      want = 16'(ai * bi);
      checks++;
      if (lat !== 25) begin errors++; $display("FAIL random_latency: got %0d want 25", lat); end
      checks++;
      if (mp !== prev) begin
        errors++; $display("FAIL random_hold: got %0d want %0d", mp, prev);
      end
      checks++;
      if (product !== want) begin
        errors++; $display("FAIL random_product %0d*%0d: got %0d want %0d", ai, bi, product, want);
      end
      checks++;
      if (seg !== exp_seg(want)) begin
        errors++; $display("FAIL random_seg %0d: got %b want %b", want, seg, exp_seg(want));
      end
      prev = want;
    end
  endtask

  task automatic test_start_held;
    int ndone;
    bit late_busy;
    bit seen;
    a = 8'd100;
    b = 8'd200;
    start = 1'b1;
    tick;
    ndone = 0;
    late_busy = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      tick;
      if (seen && busy) late_busy = 1'b1;
      if (done) begin
        ndone++;
        seen = 1'b1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL held_done_count: got %0d want 1", ndone); end
    checks++;
    if (product !== 16'd20000) begin
      errors++; $display("FAIL held_product: got %0d want 20000", product);
    end
    checks++;
    if (seg !== exp_seg(20000)) begin
      errors++; $display("FAIL held_seg: got %b want %b", seg, exp_seg(20000));
    end
    checks++;
    if (late_busy) begin errors++; $display("FAIL held_restart: got busy=1 want 0"); end
  endtask

  task automatic test_reset_abort;
    int lat;
    bit bok;
    logic [15:0] mp;
    int ndone;
    a = 8'd123;
    b = 8'd45;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++;
    if (product !== 16'd0) begin
      errors++; $display("FAIL abort_product: got %0d want 0", product);
    end
    checks++;
    if (seg !== {35{1'b1}}) begin errors++; $display("FAIL abort_seg: got %b want all ones", seg); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", ndone); end
    run_op(8'd123, 8'd45, lat, bok, mp);
    checks++;
    if (lat !== 25) begin errors++; $display("FAIL abort_rerun_latency: got %0d want 25", lat); end
    checks++;
    if (product !== 16'd5535) begin
      errors++; $display("FAIL abort_rerun_product: got %0d want 5535", product);
    end
    checks++;
    if (seg !== exp_seg(5535)) begin
      errors++; $display("FAIL abort_rerun_seg: got %b want %b", seg, exp_seg(5535));
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    bit got1;
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    tick;
    start = 1'b0;
    got1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (done) begin
        got1 = 1'b1;
        break;
      end
    end
    checks++;
    if (!got1) begin errors++; $display("FAIL b2b_first_done: got 0 want 1"); end
    checks++;
    if (product !== 16'd81) begin errors++; $display("FAIL b2b_first: got %0d want 81", product); end
    a = 8'd255;
    b = 8'd1;
    start = 1'b1;
    gap = -1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (i == 1) start = 1'b0;
      if (done) begin
        gap = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (gap !== 26) begin errors++; $display("FAIL b2b_gap: got %0d want 26", gap); end
    checks++;
    if (product !== 16'd255) begin errors++; $display("FAIL b2b_second: got %0d want 255", product); end
    checks++;
    if (seg !== exp_seg(255)) begin
      errors++; $display("FAIL b2b_seg: got %b want %b", seg, exp_seg(255));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset;
    test_directed;
    test_random;
    test_start_held;
    test_reset_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
